button_event_gen: RTL



---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_hold_timer.sv | 35 +++
 rtl/button_event_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and default timing for the button event generator
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } btn_state_e;

   // Defaults for the 100 MHz board clock: 1 s to long-press, 250 ms auto-repeat.
   localparam int DEF_LONG_CYCLES   = 100_000_000;
   localparam int DEF_REPEAT_CYCLES = 25_000_000;
   localparam int DEF_CNT_W         = 27;

endpackage

// File: rtl/btn_hold_timer.sv
// rtl/btn_hold_timer.sv - clearable up-counter flagging the last cycle before a programmable terminal
module btn_hold_timer #(
   parameter int CNT_W = 27
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] terminal,
   output logic             tc
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == (terminal - CNT_W'(1)));

endmodule

// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - turns a debounced button level into press/release/long/repeat pulses
module button_event_gen
   import btn_pkg::*;
#(
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_CYCLES);

   btn_state_e state_q, state_d;
   logic       btn_q;
   logic       press_q, press_d;
   logic       release_q, release_d;
   logic       long_q, long_d;
   logic       repeat_q, repeat_d;
   logic       held_q, held_d;

   logic             tmr_clear;
   logic             tmr_enable;
   logic [CNT_W-1:0] tmr_terminal;
   logic             tmr_tc;

   assign tmr_terminal = (state_q == ST_HELD) ? REPEAT_T : LONG_T;

   btn_hold_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .clear    (tmr_clear),
      .enable   (tmr_enable),
      .terminal (tmr_terminal),
      .tc       (tmr_tc)
   );

   // Release is tested before terminal count so it wins when both land together.
   always_comb begin
      state_d    = state_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      held_d     = 1'b0;
      tmr_clear  = 1'b0;
      tmr_enable = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (btn_level && !btn_q) begin
               state_d   = ST_PRESSED;
               tmr_clear = 1'b1;
               press_d   = 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!btn_level) begin
               state_d   = ST_IDLE;
               tmr_clear = 1'b1;
               release_d = 1'b1;
            end else if (tmr_tc) begin
               state_d   = ST_HELD;
               tmr_clear = 1'b1;
               long_d    = 1'b1;
               held_d    = 1'b1;
            end else begin
               tmr_enable = 1'b1;
            end
         end
         ST_HELD: begin
            held_d = 1'b1;
            if (!btn_level) begin
               state_d   = ST_IDLE;
               tmr_clear = 1'b1;
               release_d = 1'b1;
               held_d    = 1'b0;
            end else if (tmr_tc) begin
               tmr_clear = 1'b1;
               repeat_d  = 1'b1;
            end else begin
               tmr_enable = 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            tmr_clear = 1'b1;
         end
      endcase
   end

   // btn_q resets high so a button held through reset must be seen low before it can press.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         btn_q     <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         btn_q     <= btn_level;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         held_q    <= held_d;
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;
   assign held          = held_q;

endmodule
